// File: rtl/sha1_pkg.sv
// Shared constants and state types for the SHA-1 message padder.
package sha1_pkg;

  localparam int          SHA1_BLOCK_BITS  = 512;
  localparam int          SHA1_BLOCK_BYTES = SHA1_BLOCK_BITS / 8;
  localparam int          SHA1_LEN_BITS    = 64;
  localparam int          SHA1_LEN_OFFSET  = SHA1_BLOCK_BYTES - SHA1_LEN_BITS / 8;
  localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;

  // Padder control states.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    TAIL = 2'd2
  } pad_state_t;

  // What the extra trailing block must look like once the current block leaves.
  typedef enum logic [1:0] {
    TAIL_NONE = 2'd0,   // no extra block
    TAIL_ZERO = 2'd1,   // zeros + length (marker already placed)
    TAIL_MARK = 2'd2    // marker + zeros + length
  } tail_kind_t;

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-stream input and 512-bit block output bundle for sha1_padder.
interface sha1_padder_if
  import sha1_pkg::*;
#(
  parameter int IN_BYTES = 4
);
  logic                       i_tvalid;
  logic                       o_tready;
  logic [8*IN_BYTES-1:0]      i_tdata;
  logic [IN_BYTES-1:0]        i_tkeep;
  logic                       i_tlast;
  logic                       o_blk_tvalid;
  logic                       i_blk_tready;
  logic [SHA1_BLOCK_BITS-1:0] o_blk_tdata;
  logic                       o_blk_tlast;
  logic                       o_err;

  // Padder side.
  modport slave (
    input  i_tvalid, i_tdata, i_tkeep, i_tlast, i_blk_tready,
    output o_tready, o_blk_tvalid, o_blk_tdata, o_blk_tlast, o_err
  );

  // Stream source / block sink side.
  modport master (
    output i_tvalid, i_tdata, i_tkeep, i_tlast, i_blk_tready,
    input  o_tready, o_blk_tvalid, o_blk_tdata, o_blk_tlast, o_err
  );
endinterface

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs byte beats into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit big-endian bit length.
// Optional macro SHA1_PADDER_KEEP_CHECK_EN enables tkeep checking and o_err.
//
// state | meaning
// FILL  | accepting beats into the block buffer
// SEND  | presenting a data (or single padded) block
// TAIL  | presenting the extra length-only block
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  sha1_padder_if.slave  bus
);

  localparam int CW = $clog2(IN_BYTES + 1);

  pad_state_t                 state_q, state_d;
  logic [SHA1_BLOCK_BITS-1:0] buf_q, buf_d;
  logic [6:0]                 ptr_q, ptr_d;
  logic [SHA1_LEN_BITS-1:0]   bitcnt_q, bitcnt_d;
  logic                       tlast_q, tlast_d;
  tail_kind_t                 tail_q, tail_d;

  logic [IN_BYTES-1:0]        keep_eff;
  logic [CW-1:0]              nkeep;
  logic [6:0]                 fill_n;
  logic [SHA1_LEN_BITS-1:0]   bitcnt_new;

`ifdef SHA1_PADDER_KEEP_CHECK_EN
  logic [IN_BYTES-1:0]        keep_inv;
  logic                       keep_bad;
  logic                       err_q, err_d;
`endif

  // Effective keep: non-last beats always count as full beats.
  always_comb begin
    keep_eff = bus.i_tkeep;
    if (!bus.i_tlast) keep_eff = '1;
`ifdef SHA1_PADDER_KEEP_CHECK_EN
    // MSB-contiguous keep means its inverse is a run of ones from bit 0.
    keep_inv = ~bus.i_tkeep;
    keep_bad = ((keep_inv & (keep_inv + 1'b1)) != '0) ||
               (!bus.i_tlast && (bus.i_tkeep != '1));
    if (keep_bad) keep_eff = '1;
`endif
  end

  // Byte count of the beat and resulting fill / bit length.
  always_comb begin
    nkeep = '0;
    for (int j = 0; j < IN_BYTES; j++) nkeep = nkeep + CW'(keep_eff[j]);
    fill_n     = ptr_q + 7'(nkeep);
    bitcnt_new = bitcnt_q + (64'(nkeep) << 3);
  end

  // Next-state, buffer and padding logic.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    bitcnt_d = bitcnt_q;
    tlast_d  = tlast_q;
    tail_d   = tail_q;
`ifdef SHA1_PADDER_KEEP_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      FILL: begin
        if (bus.i_tvalid) begin
`ifdef SHA1_PADDER_KEEP_CHECK_EN
          err_d = err_q | keep_bad;
`endif
          for (int j = 0; j < IN_BYTES; j++) begin
            if ((j < int'(nkeep)) && ((int'(ptr_q) + j) < SHA1_BLOCK_BYTES))
              buf_d[(SHA1_BLOCK_BYTES - 1 - (int'(ptr_q) + j))*8 +: 8] =
                bus.i_tdata[(IN_BYTES - 1 - j)*8 +: 8];
          end
          ptr_d    = fill_n;
          bitcnt_d = bitcnt_new;
          if (bus.i_tlast) begin
            state_d = SEND;
            if (int'(fill_n) < SHA1_LEN_OFFSET) begin
              buf_d[(SHA1_BLOCK_BYTES - 1 - int'(fill_n))*8 +: 8] = SHA1_PAD_BYTE;
              buf_d[SHA1_LEN_BITS-1:0] = bitcnt_new;
              tlast_d = 1'b1;
              tail_d  = TAIL_NONE;
            end else if (int'(fill_n) < SHA1_BLOCK_BYTES) begin
              buf_d[(SHA1_BLOCK_BYTES - 1 - int'(fill_n))*8 +: 8] = SHA1_PAD_BYTE;
              tlast_d = 1'b0;
              tail_d  = TAIL_ZERO;
            end else begin
              tlast_d = 1'b0;
              tail_d  = TAIL_MARK;
            end
          end else if (int'(fill_n) == SHA1_BLOCK_BYTES) begin
            state_d = SEND;
            tlast_d = 1'b0;
            tail_d  = TAIL_NONE;
          end
        end
      end
      SEND, TAIL: begin
        if (bus.i_blk_tready) begin
          buf_d = '0;
          if (tail_q != TAIL_NONE) begin
            // Length-only block is built here and presented next cycle.
            if (tail_q == TAIL_MARK)
              buf_d[SHA1_BLOCK_BITS-1 -: 8] = SHA1_PAD_BYTE;
            buf_d[SHA1_LEN_BITS-1:0] = bitcnt_q;
            tlast_d = 1'b1;
            tail_d  = TAIL_NONE;
            state_d = TAIL;
          end else begin
            ptr_d   = '0;
            if (tlast_q) bitcnt_d = '0;
            tlast_d = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      buf_q    <= '0;
      ptr_q    <= '0;
      bitcnt_q <= '0;
      tlast_q  <= 1'b0;
      tail_q   <= TAIL_NONE;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      bitcnt_q <= bitcnt_d;
      tlast_q  <= tlast_d;
      tail_q   <= tail_d;
    end
  end

`ifdef SHA1_PADDER_KEEP_CHECK_EN
  // Sticky keep-violation flag.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_tready     = (state_q == FILL) && !reset;
  assign bus.o_blk_tvalid = (state_q != FILL);
  assign bus.o_blk_tdata  = buf_q;
  assign bus.o_blk_tlast  = tlast_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Scoreboard bench for sha1_padder (IN_BYTES = 4).
module tb_sha1_padder;
  import sha1_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha1_padder_if #(.IN_BYTES(4)) bus();
  sha1_padder #(.IN_BYTES(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_data_q[$];
  logic         exp_last_q[$];
  bit stall_en = 1'b0;
  bit gap_en   = 1'b0;
  bit hold_low = 1'b0;
  bit prev_stall = 1'b0;
  logic [511:0] held_data;
  logic         held_last;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [511:0] put(input logic [511:0] b, input int idx, input logic [7:0] v);
    logic [511:0] r;
    r = b;
    r[(63 - idx)*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] fill_blk(input bq_t m, input int cnt);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < cnt; i++) r = put(r, i, m[i]);
    return r;
  endfunction

  task automatic expect_blk(input logic [511:0] d, input logic l);
    exp_data_q.push_back(d);
    exp_last_q.push_back(l);
  endtask

  // Monitor: compare every handshaken block; check stability under stall.
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else if (bus.o_blk_tvalid) begin
      if (prev_stall) begin
        chk("stall_data", bus.o_blk_tdata, held_data);
        chk("stall_last", 512'(bus.o_blk_tlast), 512'(held_last));
      end
      if (bus.i_blk_tready) begin
        if (exp_data_q.size() == 0) chk("unexpected_block", 512'(bus.o_blk_tvalid), 512'd0);
        else begin
          chk("blk_data", bus.o_blk_tdata, exp_data_q.pop_front());
          chk("blk_last", 512'(bus.o_blk_tlast), 512'(exp_last_q.pop_front()));
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        held_data  = bus.o_blk_tdata;
        held_last  = bus.o_blk_tlast;
      end
    end else prev_stall = 1'b0;
  end

  // Block sink ready driver.
  initial begin
    int n;
    bus.i_blk_tready = 1'b1;
    forever begin
      if (hold_low) begin
        bus.i_blk_tready = 1'b0;
        @(posedge clk); #1;
      end else if (stall_en) begin
        bus.i_blk_tready = 1'b0;
        n = $urandom_range(1, 10);
        repeat (n) @(posedge clk);
        #1;
        bus.i_blk_tready = 1'b1;
        n = $urandom_range(1, 3);
        repeat (n) @(posedge clk);
        #1;
      end else begin
        bus.i_blk_tready = 1'b1;
        @(posedge clk); #1;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int budget;
    if (gap_en) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
    end
    bus.i_tdata  = d;
    bus.i_tkeep  = k;
    bus.i_tlast  = l;
    bus.i_tvalid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (bus.o_tready) break;
      budget++;
      if (budget > 500) begin
        chk("beat_timeout", 512'(bus.o_tready), 512'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tkeep  = '0;
    bus.i_tlast  = 1'b0;
  endtask

  task automatic send_msg(input bq_t m);
    int len;
    logic [31:0] d;
    logic [3:0]  k;
    len = m.size();
    if (len == 0) send_beat(32'h0, 4'b0000, 1'b1);
    else begin
      for (int off = 0; off < len; off += 4) begin
        d = '0;
        k = '0;
        for (int j = 0; j < 4; j++) begin
          if (off + j < len) begin
            d[31 - 8*j -: 8] = m[off + j];
            k[3 - j] = 1'b1;
          end
        end
        send_beat(d, k, (off + 4 >= len));
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_data_q.size() != 0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_data_q.size() != 0) chk("drain_timeout", 512'(exp_data_q.size()), 512'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m56, m64, m60, m6, mx;
    reset = 1'b1;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tkeep  = '0;
    bus.i_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready",  512'(bus.o_tready),     512'd0);
    chk("rst_tvalid",  512'(bus.o_blk_tvalid), 512'd0);
    chk("rst_tlast",   512'(bus.o_blk_tlast),  512'd0);
    chk("rst_err",     512'(bus.o_err),        512'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 512'(bus.o_tready), 512'd1);
    @(posedge clk); #1;

    // "abc" with latency check
    expect_blk({32'h61626380, 416'h0, 64'h18}, 1'b1);
    send_beat(32'h61626300, 4'b1110, 1'b1);
    @(negedge clk);
    chk("latency_valid", 512'(bus.o_blk_tvalid), 512'd1);
    chk("send_tready",   512'(bus.o_tready),     512'd0);
    @(posedge clk); #1;
    drain();

    // empty message
    expect_blk({8'h80, 440'h0, 64'h0}, 1'b1);
    send_beat(32'h0, 4'b0000, 1'b1);
    drain();

    // 56 bytes: marker lands at byte 56, length in a second block
    m56 = s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    expect_blk(put(fill_blk(m56, 56), 56, 8'h80), 1'b0);
    expect_blk({448'h0, 64'h1C0}, 1'b1);
    send_msg(m56);
    drain();

    // 64 bytes: marker starts the second block
    m64 = {};
    for (int i = 0; i < 64; i++) m64.push_back(8'(i));
    expect_blk(fill_blk(m64, 64), 1'b0);
    expect_blk({8'h80, 440'h0, 64'h200}, 1'b1);
    send_msg(m64);
    drain();

    // 6 bytes over two beats
    m6 = s2q("abcdef");
    expect_blk({48'h616263646566, 8'h80, 392'h0, 64'h30}, 1'b1);
    send_msg(m6);
    drain();

    // 60 bytes: marker at 60, length-only tail
    m60 = {};
    for (int i = 0; i < 60; i++) m60.push_back(8'(i) ^ 8'h5A);
    expect_blk(put(fill_blk(m60, 60), 60, 8'h80), 1'b0);
    expect_blk({448'h0, 64'h1E0}, 1'b1);
    send_msg(m60);
    drain();

    // random sink stalls and source gaps
    stall_en = 1'b1;
    gap_en   = 1'b1;
    expect_blk({32'h61626380, 416'h0, 64'h18}, 1'b1);
    send_msg(s2q("abc"));
    expect_blk({48'h616263646566, 8'h80, 392'h0, 64'h30}, 1'b1);
    send_msg(m6);
    expect_blk(fill_blk(m64, 64), 1'b0);
    expect_blk({8'h80, 440'h0, 64'h200}, 1'b1);
    send_msg(m64);
    expect_blk({448'h0, 64'h0} | put(put(512'h0, 0, 8'h80), 0, 8'h80), 1'b1);
    send_msg(mx);
    drain();
    stall_en = 1'b0;
    gap_en   = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

    // reset mid-message: partial message must vanish
    send_beat(32'h78797a77, 4'b1111, 1'b0);
    send_beat(32'h78797a77, 4'b1111, 1'b0);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    expect_blk({32'h61626380, 416'h0, 64'h18}, 1'b1);
    send_msg(s2q("abc"));
    drain();

    // reset mid-SEND: held full block must never be delivered
    hold_low = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 16; b++) send_beat(32'hA5A5A5A5, 4'b1111, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("held_valid", 512'(bus.o_blk_tvalid), 512'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    hold_low = 1'b0;
    @(posedge clk); #1;
    expect_blk({48'h616263646566, 8'h80, 392'h0, 64'h30}, 1'b1);
    send_msg(m6);
    drain();

`ifdef SHA1_PADDER_KEEP_CHECK_EN
    // bad keep on a non-last beat is flagged and treated as full
    expect_blk({32'h01020304, 8'h80, 408'h0, 64'h20}, 1'b1);
    send_beat(32'h01020304, 4'b1010, 1'b0);
    @(negedge clk);
    chk("err_set", 512'(bus.o_err), 512'd1);
    @(posedge clk); #1;
    send_beat(32'h0, 4'b0000, 1'b1);
    drain();
    @(negedge clk);
    chk("err_sticky", 512'(bus.o_err), 512'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", 512'(bus.o_err), 512'd0);
    @(posedge clk); #1;
`else
    // without checking, a non-last beat counts as full and o_err stays low
    expect_blk({32'h01020304, 8'h80, 408'h0, 64'h20}, 1'b1);
    send_beat(32'h01020304, 4'b1010, 1'b0);
    send_beat(32'h0, 4'b0000, 1'b1);
    drain();
    @(negedge clk);
    chk("err_tied_low", 512'(bus.o_err), 512'd0);
    @(posedge clk); #1;
`endif

    repeat (20) begin @(posedge clk); #1; end
    chk("queue_empty", 512'(exp_data_q.size()), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha1_padder.md
SHA1_PADDER -- requirements
Module: sha1_padder

Interface
REQ-001 SHALL have parameter IN_BYTES, default 4, input beat width in bytes (legal 1, 2, 4, 8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_tvalid  input  1  message beat valid.
REQ-005 SHALL have port o_tready  output  1  padder accepts beat.
REQ-006 SHALL have port i_tdata  input  8*IN_BYTES  message bytes, first byte in MSBs.
REQ-007 SHALL have port i_tkeep  input  IN_BYTES  byte valid, MSB-contiguous.
REQ-008 SHALL have port i_tlast  input  1  last beat of message.
REQ-009 SHALL have port o_blk_tvalid  output  1  512-bit block valid.
REQ-010 SHALL have port i_blk_tready  input  1  block sink ready.
REQ-011 SHALL have port o_blk_tdata  output  512  padded block, byte 0 at [511:504].
REQ-012 SHALL have port o_blk_tlast  output  1  final block of message.
REQ-013 SHALL have port o_err  output  1  sticky tkeep violation flag.

Function
REQ-014 SHALL implement FSM states FILL, SEND, TAIL.
REQ-015 FILL: o_tready=1; each accepted beat writes its kept bytes at byte pointer ptr (0..63); ptr advances by popcount(i_tkeep); 64-bit bit counter advances by 8*popcount, wrapping modulo 2^64.
REQ-016 Non-last beat filling ptr to 64 SHALL move to SEND with o_blk_tlast=0.
REQ-017 Last beat with final fill n: n<=55 -> write 0x80 at n, zeros, bit count big-endian at bytes 56..63, SEND with tlast=1.
REQ-018 Last beat with 56<=n<=63 -> write 0x80 at n, zeros to 63, SEND with tlast=0, then TAIL block = 56 zero bytes + length, tlast=1.
REQ-019 Last beat with n=64 -> SEND with tlast=0, then TAIL block = 0x80, 55 zero bytes, length, tlast=1.
REQ-020 Empty message: tlast beat with i_tkeep=0 SHALL be legal and produce one block 0x80, zeros, length 0.
REQ-021 o_blk_tvalid SHALL assert the cycle after the beat completing a block (latency 1); o_tready=0 in SEND and TAIL.
REQ-022 o_blk_tdata and o_blk_tlast SHALL hold stable while o_blk_tvalid=1 and i_blk_tready=0.
REQ-023 On block handshake: tlast=0 with pending tail -> TAIL (block built in that cycle, valid next cycle); tlast=0 otherwise -> FILL, ptr=0; tlast=1 -> FILL, ptr=0, bit counter=0.
REQ-024 With IN_BYTES dividing 64, a beat SHALL never straddle blocks.

Reset
REQ-025 Reset SHALL force state FILL, ptr=0, bit counter=0, buffer zeroed, o_blk_tvalid=0, o_blk_tlast=0, o_err=0, o_tready=0 during reset, 1 the first cycle after.
REQ-026 Reset mid-message or mid-SEND SHALL discard the partial message and emit no further block for it.

Configuration
REQ-027 With SHA1_PADDER_KEEP_CHECK_EN defined: non-contiguous i_tkeep, or i_tkeep not all-ones on a non-last beat, SHALL set o_err (sticky until reset) and the beat SHALL be processed as all-ones.
REQ-028 Without SHA1_PADDER_KEEP_CHECK_EN: o_err SHALL be tied 0; i_tkeep on non-last beats treated as all-ones, no checking.

Structure
REQ-029 Package sha1_pkg SHALL hold SHA1_BLOCK_BITS=512, SHA1_LEN_BITS=64, pad marker byte 0x80, and the padder state enum typedef.
REQ-030 Single module; no sub-module; output plugs directly into the sha1_top input stream (i_tkeep tied all-ones there).

Verification
REQ-031 "abc": one beat 0x61626300, keep 4'b1110, last -> one block 0x61626380, zeros, final word 0x00000018, tlast=1.
REQ-032 Empty message (keep 0, last) -> block 0x80000000, zeros, length 0, tlast=1; chained to sha1_top -> da39a3ee5e6b4b0d3255bfef95601890afd80709.
REQ-033 56-byte "abcdbcdecdef...nopq" -> two blocks, first ends 0x80 at byte 56 tlast=0, second zeros + 0x1C0 tlast=1; digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-034 64-byte message -> two blocks, second starts 0x80, length 0x200, tlast=1.
REQ-035 Random i_blk_tready low 1..10 cycles and random i_tvalid gaps -> blocks stable under stall, "abc" digest a9993e364706816aba3e25717850c26c9cd0d89d; reset mid-message -> no block, next message correct.
REQ-036 With SHA1_PADDER_KEEP_CHECK_EN: keep 4'b1010 on a beat -> o_err=1 until reset.
